// File: rtl/mac_pkg.sv
// Shared types for the MAC operand sequencer: FSM states, operand width,
// and the operand-pair bundle.
package mac_pkg;

  localparam int OP_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
    logic            first;
    logic            last;
  } mac_pair_t;

endpackage

// File: rtl/mac_pair_fifo.sv
// Small synchronous FIFO holding {A,B} operand pairs. The head entry is
// read combinationally so a pair pushed in one cycle is visible the next.
module mac_pair_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [PTR_W:0]    count_reg;
  logic              push_ok;
  logic              pop_ok;

  assign full      = (count_reg == (PTR_W+1)'(DEPTH));
  assign empty     = (count_reg == '0);
  assign push_ok   = push && !full;
  assign pop_ok    = pop && !empty;
  assign head_data = mem_reg[rd_ptr_reg];

  // Storage write; contents need no reset because empty gates all use.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/mac_operand_sequencer.sv
// Pairs a byte stream into (A,B) operands, buffers them, and issues exactly
// cfg_len pairs to the MAC with first/last flags, pulsing done at the end.
module mac_operand_sequencer
  import mac_pkg::*;
#(
  parameter int LEN_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [OP_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OP_W-1:0]  mac_a,
  output logic [OP_W-1:0]  mac_b,
  output logic             mac_first,
  output logic             mac_last,
  output logic             mac_valid,
  input  logic             mac_ready,
  output logic             busy,
  output logic             done
);

  state_t             state_reg, state_next;
  logic [LEN_W-1:0]   len_reg;
  logic [LEN_W-1:0]   pairs_in_reg;
  logic [LEN_W-1:0]   pairs_out_reg;
  logic               half_reg;
  logic [OP_W-1:0]    a_hold_reg;

  logic               fifo_full;
  logic               fifo_empty;
  logic [2*OP_W-1:0]  fifo_head;
  logic               in_fire;
  logic               push;
  logic               pop;
  mac_pair_t          pair_out;

  assign in_fire = in_valid && in_ready;
  assign push    = in_fire && half_reg;
  assign pop     = mac_valid && mac_ready;

  mac_pair_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (2*OP_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({a_hold_reg, in_data}),
    .pop       (pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next state and handshake outputs; in_ready depends only on registered state.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    mac_valid  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = (cfg_len != '0) ? RUN : DONE;
      end
      RUN: begin
        busy      = 1'b1;
        in_ready  = (pairs_in_reg < len_reg) && !(half_reg && fifo_full);
        mac_valid = !fifo_empty;
        if (mac_valid && mac_ready && (pairs_out_reg == len_reg - LEN_W'(1))) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Byte pairing and pair counters; counts stop at len_reg so never wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_reg       <= '0;
      pairs_in_reg  <= '0;
      pairs_out_reg <= '0;
      half_reg      <= 1'b0;
      a_hold_reg    <= '0;
    end else if (state_reg == IDLE) begin
      if (start) begin
        len_reg       <= cfg_len;
        pairs_in_reg  <= '0;
        pairs_out_reg <= '0;
        half_reg      <= 1'b0;
      end
    end else if (state_reg == RUN) begin
      if (in_fire) begin
        if (!half_reg) begin
          a_hold_reg <= in_data;
          half_reg   <= 1'b1;
        end else begin
          half_reg     <= 1'b0;
          pairs_in_reg <= pairs_in_reg + 1'b1;
        end
      end
      if (pop) pairs_out_reg <= pairs_out_reg + 1'b1;
    end
  end

  // Present the FIFO head as a pair; everything reads 0 when nothing is valid.
  always_comb begin
    pair_out       = '0;
    if (mac_valid) begin
      pair_out.a     = fifo_head[2*OP_W-1:OP_W];
      pair_out.b     = fifo_head[OP_W-1:0];
      pair_out.first = (pairs_out_reg == '0);
      pair_out.last  = (pairs_out_reg == len_reg - LEN_W'(1));
    end
  end

  assign mac_a     = pair_out.a;
  assign mac_b     = pair_out.b;
  assign mac_first = pair_out.first;
  assign mac_last  = pair_out.last;

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Randomized bench for mac_operand_sequencer against a queue-based model of
// vector pairing, buffering and issue.
module tb_mac_operand_sequencer;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] cfg_len = '0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] mac_a, mac_b;
  logic       mac_first, mac_last, mac_valid;
  logic       mac_ready = 1'b0;
  logic       busy, done;

  mac_operand_sequencer #(.LEN_W(8), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mac_a(mac_a), .mac_b(mac_b), .mac_first(mac_first), .mac_last(mac_last),
    .mac_valid(mac_valid), .mac_ready(mac_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: vector in flight, bytes taken, pairs buffered/issued.
  logic [7:0]  bq[$];
  logic [15:0] pq[$];
  bit          m_run, m_done;
  int          m_len, m_bytes, m_out;
  logic [7:0]  m_ahold;

  // Golden dot product of the bytes loaded for the current vector.
  int          ref_sum, load_cnt;
  logic [7:0]  load_prev;

  // Observations of the DUT.
  int dut_sum, first_cnt, last_cnt, done_cnt, dut_bytes;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_bytes();
    bq.delete();
    ref_sum = 0; load_cnt = 0;
  endtask

  task automatic load_byte(input logic [7:0] b);
    bq.push_back(b);
    if (load_cnt % 2 == 1) ref_sum += int'(load_prev) * int'(b);
    else load_prev = b;
    load_cnt++;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_mac_valid"}, mac_valid, 0);
    check({tag, "_mac_first"}, mac_first, 0);
    check({tag, "_mac_last"}, mac_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_mac_a"}, mac_a, 0);
    check({tag, "_mac_b"}, mac_b, 0);
  endtask

  // One clock: check outputs against the model, drive inputs, advance model.
  task automatic cycle(input logic st, input logic [7:0] ln, input int pv, input int pr);
    int pin, occ;
    bit half, exp_ir, exp_mv, in_fire, mac_fire;
    logic [7:0] b;
    @(negedge clk);
    pin = m_bytes / 2; half = (m_bytes % 2) == 1; occ = pq.size();
    exp_ir = m_run && (pin < m_len) && !(half && occ == DEPTH);
    exp_mv = m_run && (occ > 0);
    check("in_ready", in_ready, exp_ir);
    check("mac_valid", mac_valid, exp_mv);
    check("mac_first", mac_first, exp_mv && m_out == 0);
    check("mac_last", mac_last, exp_mv && m_out == m_len - 1);
    check("busy", busy, m_run || m_done);
    check("done", done, m_done);
    if (exp_mv) begin
      check("mac_a", mac_a, pq[0][15:8]);
      check("mac_b", mac_b, pq[0][7:0]);
    end
    if (done) done_cnt++;
    start = st; cfg_len = ln;
    in_valid  = (bq.size() > 0) && ($urandom_range(99) < pv);
    in_data   = in_valid ? bq[0] : 8'($urandom);
    mac_ready = ($urandom_range(99) < pr);
    in_fire  = in_valid && exp_ir;
    mac_fire = exp_mv && mac_ready;
    if (in_valid && in_ready) dut_bytes++;
    if (mac_valid && mac_ready) begin
      if (mac_first) begin dut_sum = int'(mac_a) * int'(mac_b); first_cnt++; end
      else dut_sum += int'(mac_a) * int'(mac_b);
      if (mac_last) last_cnt++;
    end
    @(posedge clk);
    if (m_done) begin
      m_done = 0;
    end else if (!m_run) begin
      if (st) begin
        m_len = int'(ln); m_bytes = 0; m_out = 0; pq.delete();
        m_run = (ln != 0); m_done = (ln == 0);
      end
    end else begin
      if (mac_fire) begin
        void'(pq.pop_front());
        m_out++;
        if (m_out == m_len) begin m_run = 0; m_done = 1; end
      end
      if (in_fire) begin
        b = bq.pop_front();
        if (half) pq.push_back({m_ahold, b});
        else m_ahold = b;
        m_bytes++;
      end
    end
  endtask

  task automatic begin_vec(input int len, input int pv, input int pr);
    dut_sum = 0; first_cnt = 0; last_cnt = 0; done_cnt = 0; dut_bytes = 0;
    cycle(1'b1, 8'(len), pv, pr);
  endtask

  task automatic run_to_end(input string tag, input int pv, input int pr);
    int budget = 2000;
    while ((m_run || m_done) && budget > 0) begin
      cycle(1'b0, 8'd0, pv, pr);
      budget--;
    end
    if (budget == 0) check({tag, "_timeout"}, 1, 0);
  endtask

  task automatic vec_checks(input string tag);
    check({tag, "_sum"}, dut_sum, ref_sum);
    check({tag, "_first_cnt"}, first_cnt, 1);
    check({tag, "_last_cnt"}, last_cnt, 1);
    check({tag, "_done_cnt"}, done_cnt, 1);
  endtask

  task automatic reset_dut(input string tag);
    @(negedge clk);
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; mac_ready = 1'b0;
    @(posedge clk);
    m_run = 0; m_done = 0; m_len = 0; m_bytes = 0; m_out = 0; pq.delete();
    @(negedge clk);
    check_zero(tag);
    rst = 1'b0;
  endtask

  initial begin
    int budget;
    m_run = 0; m_done = 0; m_len = 0; m_bytes = 0; m_out = 0; m_ahold = '0;
    clear_bytes();
    dut_sum = 0; first_cnt = 0; last_cnt = 0; done_cnt = 0; dut_bytes = 0;
    repeat (3) @(posedge clk);
    reset_dut("reset");

    // Three-pair vector, free-flowing handshakes.
    clear_bytes();
    for (int i = 2; i <= 7; i++) load_byte(8'(i));
    begin_vec(3, 100, 100);
    run_to_end("len3", 100, 100);
    vec_checks("len3");
    check("len3_sum_const", dut_sum, 32'h44);
    $display("[TB] vector len=3 sum=%0d", dut_sum);

    // Zero-length vector: done next cycle, no traffic even with bytes offered.
    clear_bytes();
    for (int i = 0; i < 4; i++) load_byte(8'($urandom));
    begin_vec(0, 100, 100);
    run_to_end("len0", 100, 100);
    check("len0_done_cnt", done_cnt, 1);
    check("len0_first_cnt", first_cnt, 0);
    repeat (3) cycle(1'b0, 8'd0, 100, 100);
    check("len0_bytes", dut_bytes, 0);
    $display("[TB] vector len=0 done_cnt=%0d", done_cnt);

    // Back-pressure: FIFO fills, one extra A-byte taken, then drain.
    clear_bytes();
    for (int i = 0; i < 12; i++) load_byte(8'($urandom));
    begin_vec(6, 100, 0);
    repeat (14) cycle(1'b0, 8'd0, 100, 0);
    check("fill_bytes", dut_bytes, 9);
    check("fill_in_ready", in_ready, 0);
    run_to_end("fill", 100, 100);
    vec_checks("fill");
    $display("[TB] vector len=6 stalled sum=%0d", dut_sum);

    // Random toggling on both handshakes.
    for (int v = 0; v < 3; v++) begin
      clear_bytes();
      for (int i = 0; i < 40; i++) load_byte(8'($urandom));
      begin_vec(20, 60, 50);
      run_to_end("rand", 60, 50);
      vec_checks("rand");
      $display("[TB] vector len=20 random sum=%0d ref=%0d", dut_sum, ref_sum);
    end

    // Reset with 2 of 5 pairs issued and 1 buffered, then a one-pair vector.
    clear_bytes();
    for (int i = 0; i < 10; i++) load_byte(8'($urandom));
    begin_vec(5, 100, 100);
    budget = 100;
    while (!(m_out == 2 && pq.size() == 1) && budget > 0) begin
      cycle(1'b0, 8'd0, 100, (m_out < 2) ? 100 : 0);
      budget--;
    end
    if (budget == 0) check("midrst_timeout", 1, 0);
    reset_dut("midrst");
    clear_bytes();
    load_byte(8'hFF); load_byte(8'hFF);
    begin_vec(1, 100, 100);
    run_to_end("ffff", 100, 100);
    vec_checks("ffff");
    $display("[TB] vector after reset sum=%0d", dut_sum);

    // start during RUN with another length is ignored.
    clear_bytes();
    for (int i = 0; i < 8; i++) load_byte(8'($urandom));
    begin_vec(4, 70, 70);
    repeat (3) cycle(1'b0, 8'd0, 70, 70);
    cycle(1'b1, 8'd9, 70, 70);
    run_to_end("restart", 70, 70);
    vec_checks("restart");
    $display("[TB] vector len=4 with ignored start sum=%0d", dut_sum);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
